// File: rtl/if_fetch_queue_if.sv
// Fetch-queue handshake bundle: pre-IF enqueue, inst-sram response, flush and ID-side delivery.
// master drives fetches/responses/flush and consumes instructions; slave is the queue itself.
interface if_fetch_queue_if #(
  parameter int DATA_W  = 32,
  parameter int VADDR_W = 32
);
  logic               pfs_valid;
  logic [VADDR_W-1:0] pfs_pc;
  logic               pfs_ex;
  logic [4:0]         pfs_exccode;
  logic               fs_allowin;
  logic               inst_data_ok;
  logic [DATA_W-1:0]  inst_rdata;
  logic               flush;
  logic               ds_allowin;
  logic               ds_valid;
  logic [DATA_W-1:0]  ds_inst;
  logic [VADDR_W-1:0] ds_pc;
  logic               ds_ex;
  logic [4:0]         ds_exccode;
  logic               fs_busy;

  modport master (
    output pfs_valid, pfs_pc, pfs_ex, pfs_exccode, inst_data_ok, inst_rdata, flush, ds_allowin,
    input  fs_allowin, ds_valid, ds_inst, ds_pc, ds_ex, ds_exccode, fs_busy
  );

  modport slave (
    input  pfs_valid, pfs_pc, pfs_ex, pfs_exccode, inst_data_ok, inst_rdata, flush, ds_allowin,
    output fs_allowin, ds_valid, ds_inst, ds_pc, ds_ex, ds_exccode, fs_busy
  );
endinterface

// File: rtl/if_fetch_queue.sv
// In-order IF fetch queue: up to DEPTH outstanding fetches, 0-cycle bypass from data_ok to ID.
// Backpressure: stalls pre-IF when full or flushing; returned instructions are held while ID stalls.
module if_fetch_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int VADDR_W = 32
) (
  input logic            clk,
  input logic            reset,
  if_fetch_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [VADDR_W-1:0] pc_q   [DEPTH];
  logic               ex_q   [DEPTH];
  logic [4:0]         exc_q  [DEPTH];
  logic [DATA_W-1:0]  inst_q [DEPTH];
  logic               done_q [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr, fill_ptr, scan_idx;
  logic [CW-1:0] count, cancel_cnt, outst;
  logic          fill_found, live_ok, fill_en, head_done, enq, deq;

  // Fill target is the oldest queued entry still waiting for its response.
  always_comb begin
    fill_ptr   = rd_ptr;
    fill_found = 1'b0;
    scan_idx   = rd_ptr;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PW'(i);
      if (!fill_found && (CW'(i) < count) && !done_q[scan_idx]) begin
        fill_ptr   = scan_idx;
        fill_found = 1'b1;
      end
    end
  end

  assign live_ok        = bus.inst_data_ok && (cancel_cnt == '0);
  assign fill_en        = live_ok && fill_found;
  assign head_done      = done_q[rd_ptr];
  assign bus.fs_allowin = (count != CW'(DEPTH)) && !bus.flush;
  assign bus.ds_valid   = (count != '0) && !bus.flush &&
                          (head_done || (fill_en && (fill_ptr == rd_ptr)));
  assign bus.ds_inst    = ex_q[rd_ptr] ? '0 : (head_done ? inst_q[rd_ptr] : bus.inst_rdata);
  assign bus.ds_pc      = pc_q[rd_ptr];
  assign bus.ds_ex      = ex_q[rd_ptr];
  assign bus.ds_exccode = exc_q[rd_ptr];
  assign bus.fs_busy    = (count != '0) || (cancel_cnt != '0);

  assign enq = bus.pfs_valid && bus.fs_allowin;
  assign deq = bus.ds_valid && bus.ds_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      outst      <= '0;
      cancel_cnt <= '0;
    end else if (bus.flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count      <= '0;
      outst      <= '0;
      // A response landing in the flush cycle pays for its own request.
      cancel_cnt <= cancel_cnt + outst - CW'(bus.inst_data_ok);
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(1);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(enq) - CW'(deq);
      outst <= outst + CW'(enq && !bus.pfs_ex) - CW'(fill_en);
      if (bus.inst_data_ok && (cancel_cnt != '0)) cancel_cnt <= cancel_cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[wr_ptr]   <= bus.pfs_pc;
      ex_q[wr_ptr]   <= bus.pfs_ex;
      exc_q[wr_ptr]  <= bus.pfs_exccode;
      done_q[wr_ptr] <= bus.pfs_ex;
    end
    if (fill_en) begin
      inst_q[fill_ptr] <= bus.inst_rdata;
      done_q[fill_ptr] <= 1'b1;
    end
  end

  a_no_orphan_response: assert property (@(posedge clk) disable iff (reset)
    !(bus.inst_data_ok && (outst == '0) && (cancel_cnt == '0)));
endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized + directed bench for if_fetch_queue: transaction-level model of queue, sram and flush.
module tb_if_fetch_queue;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  if_fetch_queue_if #(.DATA_W(32), .VADDR_W(32)) bus ();
  if_fetch_queue #(.DEPTH(DEPTH), .DATA_W(32), .VADDR_W(32)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic        ex;
    logic [4:0]  exc;
    logic [31:0] data;
    bit          got;
  } ent_t;

  ent_t        exp_q[$];   // fetches accepted and not yet delivered, oldest first
  logic [31:0] owed_q[$];  // responses the sram still owes, in order
  int          stale = 0;  // leading owed responses belonging to flushed fetches
  bit          p_enq = 0, p_flush = 0;
  ent_t        p_ent;
  bit          exp_allow, exp_busy;
  int          tests = 0, fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Commit what the previous cycle's edge did: enqueue or flush.
  task automatic apply_prev();
    int o;
    if (p_flush) begin
      o = 0;
      foreach (exp_q[i]) if (!exp_q[i].ex && !exp_q[i].got) o++;
      stale += o;
      exp_q.delete();
    end else if (p_enq) begin
      exp_q.push_back(p_ent);
      if (!p_ent.ex) owed_q.push_back(p_ent.data);
    end
    p_enq   = 0;
    p_flush = 0;
  endtask

  task automatic drive(input bit pv, input logic [31:0] pc, input bit ex, input logic [4:0] exc,
                       input bit dok, input bit dsa, input bit fl);
    bit   marked;
    ent_t t;
    @(posedge clk);
    apply_prev();
    #1;
    if (!ex && owed_q.size() >= DEPTH) pv = 0;
    if (owed_q.size() == 0) dok = 0;
    exp_busy  = (exp_q.size() != 0) || (stale != 0);
    exp_allow = (exp_q.size() != DEPTH) && !fl;
    reset            = 1'b0;
    bus.pfs_valid    = pv;
    bus.pfs_pc       = pc;
    bus.pfs_ex       = ex;
    bus.pfs_exccode  = exc;
    bus.inst_data_ok = dok;
    bus.inst_rdata   = $urandom;
    bus.ds_allowin   = dsa;
    bus.flush        = fl;
    if (dok) begin
      bus.inst_rdata = owed_q.pop_front();
      if (stale > 0) stale--;
      else begin
        marked = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
          if (!marked && !exp_q[i].ex && !exp_q[i].got) begin
            t = exp_q[i];
            t.got = 1;
            exp_q[i] = t;
            marked = 1;
          end
        end
      end
    end
    p_enq   = pv && exp_allow;
    p_flush = fl;
    p_ent   = '{pc, ex, exc, $urandom, 1'b0};
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset            = 1'b1;
    bus.pfs_valid    = 0;
    bus.inst_data_ok = 0;
    bus.flush        = 0;
    bus.ds_allowin   = 0;
    exp_q.delete();
    owed_q.delete();
    stale   = 0;
    p_enq   = 0;
    p_flush = 0;
  endtask

  // Monitor: compares every non-reset cycle, pops the scoreboard on each delivery.
  initial begin
    bit   ev;
    ent_t h;
    forever begin
      @(negedge clk);
      if (!reset) begin
        ev = !bus.flush && (exp_q.size() > 0) && (exp_q[0].ex || exp_q[0].got);
        chk("fs_allowin", 32'(bus.fs_allowin), 32'(exp_allow));
        chk("fs_busy", 32'(bus.fs_busy), 32'(exp_busy));
        chk("ds_valid", 32'(bus.ds_valid), 32'(ev));
        if (ev) begin
          h = exp_q[0];
          chk("ds_pc", bus.ds_pc, h.pc);
          chk("ds_ex", 32'(bus.ds_ex), 32'(h.ex));
          chk("ds_inst", bus.ds_inst, h.ex ? 32'h0 : h.data);
          if (h.ex) chk("ds_exccode", 32'(bus.ds_exccode), 32'(h.exc));
          if (bus.ds_allowin) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [31:0] rpc;
    bus.pfs_valid = 0; bus.pfs_pc = 0; bus.pfs_ex = 0; bus.pfs_exccode = 0;
    bus.inst_data_ok = 0; bus.inst_rdata = 0; bus.flush = 0; bus.ds_allowin = 0;
    repeat (3) @(posedge clk);

    // Pipelined fetch with bypass delivery.
    for (int i = 0; i < 5; i++) drive(i < 4, 32'hBFC00000 + 32'(4 * i), 0, 0, i > 0, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);

    // Fill to full under ID stall, extra fetch refused, then drain.
    for (int i = 0; i < 4; i++) drive(1, 32'hBFC00100 + 32'(4 * i), 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 0, 0, 1, 0, 0);
    drive(1, 32'hBFC00200, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 0, 1, 0);

    // Flush with 3 outstanding and a response in the flush cycle.
    for (int i = 0; i < 3; i++) drive(1, 32'hBFC00300 + 32'(4 * i), 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 1, 0, 1);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(1, 32'hBFC00380, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 0, 1, 0);

    // Fetch exception between two normal fetches.
    drive(1, 32'hBFC00400, 0, 0, 0, 1, 0);
    drive(1, 32'hBFC00404, 1, 5'h04, 0, 1, 0);
    drive(1, 32'hBFC00408, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    drive(0, 0, 0, 0, 1, 1, 0);
    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);

    // Reset with count=3 and one stale response pending.
    drive(1, 32'hBFC00500, 0, 0, 0, 0, 0);
    drive(1, 32'hBFC00504, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 32'hBFC00600 + 32'(4 * i), 0, 0, 0, 0, 0);
    do_reset();
    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) do_reset();
      rpc = $urandom & 32'hFFFF_FFFC;
      drive($urandom_range(0, 1) == 1, rpc, $urandom_range(0, 7) == 0, 5'($urandom_range(0, 31)),
            $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0);
    end
    repeat (2) drive(0, 0, 0, 0, 0, 1, 0);

    @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
